// File: rtl/ntt_butterfly_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg -- shared constants and types for the NTT butterfly pipeline.
//   WIDTH_DEF / Q_DEF : default coefficient width and prime modulus
//   K_DEF / M_DEF     : Barrett constants for the defaults (k = 2*WIDTH,
//                       m = floor(2^k / Q))
//   LAT               : register stages from operand accept to result
//   mode_e            : butterfly flavour carried alongside each operand set
//   barrett_m()       : elaboration-time floor(2^k / q) by long division, so
//                       non-default parameterisations get their own constant
// ---------------------------------------------------------------------------
package ntt_pkg;

    localparam int WIDTH_DEF = 14;
    localparam int Q_DEF     = 7681;
    localparam int LAT       = 3;

    typedef enum logic {
        MODE_CT = 1'b0,   // Cooley-Tukey, forward transform
        MODE_GS = 1'b1    // Gentleman-Sande, inverse transform
    } mode_e;

    // Restoring long division of 2^k by q, one quotient bit per step.
    function automatic logic [63:0] barrett_m(input int k, input int q);
        logic [64:0] rem;
        logic [63:0] quo;
        rem = '0;
        quo = '0;
        for (int i = 63; i >= 0; i--) begin
            rem = {rem[63:0], (i == k)};
            if (rem >= 65'(q)) begin
                rem    = rem - 65'(q);
                quo[i] = 1'b1;
            end
        end
        return quo;
    endfunction

    localparam int          K_DEF = 2 * WIDTH_DEF;
    localparam logic [63:0] M_DEF = barrett_m(K_DEF, Q_DEF);

endpackage

// File: rtl/ntt_butterfly_pipe_if.sv
// ---------------------------------------------------------------------------
// ntt_butterfly_pipe_if -- valid/ready operand and result channels of the
// butterfly pipeline.
//   in_valid/in_ready    : operand handshake (mode, input_1, input_2, twiddle)
//   out_valid/out_ready  : result handshake (output_1, output_2)
//   master : producer/consumer side (testbench or upstream logic)
//   slave  : the butterfly pipeline
// ---------------------------------------------------------------------------
interface ntt_butterfly_pipe_if
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] input_1;
    logic [WIDTH-1:0] input_2;
    logic [WIDTH-1:0] twiddle;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output_1;
    logic [WIDTH-1:0] output_2;

    modport master (
        output in_valid, mode, input_1, input_2, twiddle, out_ready,
        input  in_ready, out_valid, output_1, output_2
    );

    modport slave (
        input  in_valid, mode, input_1, input_2, twiddle, out_ready,
        output in_ready, out_valid, output_1, output_2
    );
endinterface

// File: rtl/mod_mult_barrett.sv
// ---------------------------------------------------------------------------
// mod_mult_barrett -- two-stage modular multiplier, r = (a * b) mod Q.
//   clk  : rising-edge clock
//   en_i : per-stage load enables, [0] = product register, [1] = result
//   a_i  : multiplicand in [0,Q-1]
//   b_i  : multiplier in [0,Q-1]
//   r_o  : reduced product in [0,Q-1], registered
// Stage 1 registers the full 2*WIDTH product; stage 2 applies Barrett
// reduction. With m = floor(2^k/Q) and t < 2^k the quotient estimate is low
// by at most one, so the remainder is below 2Q and one conditional subtract
// finishes the reduction. Data registers carry no reset: the owner only
// loads them behind a valid bit.
// ---------------------------------------------------------------------------
module mod_mult_barrett
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int Q     = Q_DEF
) (
    input  logic             clk,
    input  logic [1:0]       en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] r_o
);
    localparam int          K   = 2 * WIDTH;
    localparam logic [63:0] M   = barrett_m(K, Q);
    localparam logic [K-1:0] M_K = M[K-1:0];
    localparam logic [K-1:0] Q_K = K'(Q);

    logic [K-1:0]     prod_d, prod_q;
    logic [2*K-1:0]   tm;
    logic [K-1:0]     qhat, qq, rem, rem_sub;
    logic [WIDTH-1:0] r_d, r_q;

    assign prod_d = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    always_comb begin
        tm      = {{K{1'b0}}, prod_q} * {{K{1'b0}}, M_K};
        qhat    = tm[2*K-1:K];
        // Only the low bits matter: the true remainder is below 2Q.
        qq      = qhat * Q_K;
        rem     = prod_q - qq;
        rem_sub = rem - Q_K;
        r_d     = (rem >= Q_K) ? rem_sub[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (en_i[0]) prod_q <= prod_d;
        if (en_i[1]) r_q    <= r_d;
    end

    assign r_o = r_q;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// ntt_butterfly_pipe -- 3-stage pipelined NTT butterfly with valid/ready flow.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all stage valids and outputs
//   bus : operand/result channels (ntt_butterfly_pipe_if.slave)
// mode CT: out1 = a + b*w, out2 = a - b*w           (mod Q)
// mode GS: out1 = a + b,   out2 = (a - b)*w         (mod Q)
// S1 forms the multiplier operand (b, or a-b for GS) and the pass-through
// term (a, or a+b for GS) and registers the raw product; S2 Barrett-reduces
// it; S3 does the final add/sub and drives the outputs. Each stage advances
// when it is empty or its successor advances, so a full pipe still takes a
// new set in the same cycle the oldest one leaves.
// ---------------------------------------------------------------------------
module ntt_butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int Q     = Q_DEF
) (
    input  logic clk,
    input  logic rst,
    ntt_butterfly_pipe_if.slave bus
);
    localparam logic [WIDTH:0] Q_W1 = (WIDTH+1)'(Q);

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_W1) s = s - Q_W1;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[WIDTH]) d = d + Q_W1;   // borrow
        return d[WIDTH-1:0];
    endfunction

    logic [LAT-1:0]   vld_q, vld_d;
    logic             adv1, adv2, adv3;
    logic             ld1, ld2, ld3;
    mode_e            md1_d, md1_q, md2_q;
    logic [WIDTH-1:0] car1_d, car1_q, car2_q;
    logic [WIDTH-1:0] sum_s1, dif_s1, mul_a, prod_r;
    logic [WIDTH-1:0] out1_d, out1_q, out2_d, out2_q;

    // Backpressure ripples from the output towards the input.
    assign adv3 = bus.out_ready || !vld_q[2];
    assign adv2 = adv3 || !vld_q[1];
    assign adv1 = adv2 || !vld_q[0];

    assign ld1 = adv1 && bus.in_valid;
    assign ld2 = adv2 && vld_q[0];
    assign ld3 = adv3 && vld_q[1];

    always_comb begin
        vld_d = vld_q;
        if (adv1) vld_d[0] = bus.in_valid;
        if (adv2) vld_d[1] = vld_q[0];
        if (adv3) vld_d[2] = vld_q[1];
    end

    // S1: pre-add/sub and operand select for the multiplier.
    always_comb begin
        sum_s1 = add_mod(bus.input_1, bus.input_2);
        dif_s1 = sub_mod(bus.input_1, bus.input_2);
        md1_d  = mode_e'(bus.mode);
        if (md1_d == MODE_GS) begin
            mul_a  = dif_s1;
            car1_d = sum_s1;
        end else begin
            mul_a  = bus.input_2;
            car1_d = bus.input_1;
        end
    end

    mod_mult_barrett #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_mult (
        .clk  (clk),
        .en_i ({ld2, ld1}),
        .a_i  (mul_a),
        .b_i  (bus.twiddle),
        .r_o  (prod_r)
    );

    // S3: final combine; GS already has both results ready.
    always_comb begin
        if (md2_q == MODE_GS) begin
            out1_d = car2_q;
            out2_d = prod_r;
        end else begin
            out1_d = add_mod(car2_q, prod_r);
            out2_d = sub_mod(car2_q, prod_r);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (ld3) begin
                out1_q <= out1_d;
                out2_q <= out2_d;
            end
        end
    end

    // Side-band data only moves behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ld1) begin
            md1_q  <= md1_d;
            car1_q <= car1_d;
        end
        if (ld2) begin
            md2_q  <= md1_q;
            car2_q <= car1_q;
        end
    end

    // Held low during reset so nothing appears accepted that is discarded.
    assign bus.in_ready  = adv1 && !rst;
    assign bus.out_valid = vld_q[2];
    assign bus.output_1  = out1_q;
    assign bus.output_2  = out2_q;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_ntt_butterfly_pipe -- self-checking bench for ntt_butterfly_pipe.
// Inputs change 1 time unit after the rising edge; handshakes are evaluated
// 2 units after the edge, when everything is settled for the next edge.
// Expected results come from a modular-arithmetic reference using %.
// ---------------------------------------------------------------------------
module tb_ntt_butterfly_pipe;
    import ntt_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int QP = Q_DEF;

    typedef logic [2*W:0] wide_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_butterfly_pipe_if #(.WIDTH(W)) bif ();

    ntt_butterfly_pipe #(.WIDTH(W), .Q(QP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int nvec = 0;
    int nerr = 0;
    logic [2*W-1:0] exp_q[$];

    function automatic logic [2*W-1:0] ref_bfly(input logic md, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] w);
        wide_t wa, wb, ww, qq, p, o1, o2;
        wa = wide_t'(a); wb = wide_t'(b); ww = wide_t'(w); qq = wide_t'(QP);
        if (md == MODE_CT) begin
            p  = (wb * ww) % qq;
            o1 = (wa + p) % qq;
            o2 = (wa + qq - p) % qq;
        end else begin
            o1 = (wa + wb) % qq;
            o2 = (((wa + qq - wb) % qq) * ww) % qq;
        end
        return {o1[W-1:0], o2[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        return W'($urandom_range(0, QP - 1));
    endfunction

    task automatic set_ops(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] w);
        bif.mode = md; bif.input_1 = a; bif.input_2 = b; bif.twiddle = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.out_ready = 1'b1;
        bif.in_valid = 1'b1;   // must be ignored while in reset
        set_ops(MODE_CT, 14'd5, 14'd6, 14'd7);
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (bif.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); end
        nvec++; if (bif.output_1 !== '0) begin nerr++; $display("FAIL reset_output_1: got %0d expected 0", bif.output_1); end
        nvec++; if (bif.output_2 !== '0) begin nerr++; $display("FAIL reset_output_2: got %0d expected 0", bif.output_2); end
        rst = 1'b0;
        bif.in_valid = 1'b0;
        #1;
        nvec++; if (bif.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            nvec++; if (bif.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_no_output: cycle %0d got out_valid %b expected 0", i, bif.out_valid); end
        end
    endtask

    task automatic test_directed();
        logic          md [5] = '{MODE_CT, MODE_GS, MODE_CT, MODE_CT, MODE_GS};
        logic [W-1:0]  ta [5] = '{14'd1, 14'd1, 14'd7680, 14'd7680, 14'd0};
        logic [W-1:0]  tb [5] = '{14'd2, 14'd2, 14'd7680, 14'd1, 14'd1};
        logic [W-1:0]  tw [5] = '{14'd256, 14'd256, 14'd7680, 14'd1, 14'd7680};
        logic [W-1:0]  e1 [5] = '{14'd513, 14'd3, 14'd0, 14'd0, 14'd1};
        logic [W-1:0]  e2 [5] = '{14'd7170, 14'd7425, 14'd7679, 14'd7679, 14'd1};
        int lat;
        bif.out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            bif.in_valid = 1'b1;
            set_ops(md[v], ta[v], tb[v], tw[v]);
            #1;
            nvec++; if (bif.in_ready !== 1'b1) begin nerr++; $display("FAIL dir%0d_in_ready: got %b expected 1", v, bif.in_ready); end
            @(posedge clk); #1;
            bif.in_valid = 1'b0;
            lat = 1;
            while (bif.out_valid !== 1'b1 && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            nvec++; if (lat != 3) begin nerr++; $display("FAIL dir%0d_latency: got %0d cycles expected 3", v, lat); end
            nvec++; if (bif.output_1 !== e1[v]) begin nerr++; $display("FAIL dir%0d_output_1: got %0d expected %0d", v, bif.output_1, e1[v]); end
            nvec++; if (bif.output_2 !== e2[v]) begin nerr++; $display("FAIL dir%0d_output_2: got %0d expected %0d", v, bif.output_2, e2[v]); end
            @(posedge clk); #1;
            nvec++; if (bif.out_valid !== 1'b0) begin nerr++; $display("FAIL dir%0d_single_result: got out_valid %b expected 0", v, bif.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] e;
        logic           md;
        logic [W-1:0]   a, b, w;
        exp_q.delete();
        bif.out_ready = 1'b1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            bif.in_valid = (cyc < 8);
            md = 1'($urandom_range(0, 1)); a = rnd_op(); b = rnd_op(); w = rnd_op();
            set_ops(md, a, b, w);
            #1;
            if (cyc < 8) begin
                nvec++; if (bif.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", cyc, bif.in_ready); end
            end
            nvec++; if (bif.out_valid !== (cyc >= 3 && cyc <= 10)) begin nerr++; $display("FAIL b2b_out_valid: cycle %0d got %b expected %b", cyc, bif.out_valid, (cyc >= 3 && cyc <= 10)); end
            if (bif.in_valid && bif.in_ready) exp_q.push_back(ref_bfly(md, a, b, w));
            if (bif.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nvec++; if ({bif.output_1, bif.output_2} !== e) begin nerr++; $display("FAIL b2b_result: cycle %0d got %0d,%0d expected %0d,%0d", cyc, bif.output_1, bif.output_2, e[2*W-1:W], e[W-1:0]); end
            end
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic           md [5];
        logic [W-1:0]   a [5], b [5], w [5];
        logic [2*W-1:0] e;
        logic [W-1:0]   h1, h2;
        int sent, got, inflight, stall, cyc;
        bit first_seen, hold_chk, full_seen, exp_rdy;
        for (int i = 0; i < 5; i++) begin
            md[i] = 1'($urandom_range(0, 1)); a[i] = rnd_op(); b[i] = rnd_op(); w[i] = rnd_op();
        end
        exp_q.delete();
        sent = 0; got = 0; inflight = 0; stall = 0; cyc = 0;
        first_seen = 0; hold_chk = 0; full_seen = 0; h1 = '0; h2 = '0;
        while (got < 5 && cyc < 100) begin
            if (bif.out_valid && !first_seen) begin first_seen = 1; stall = 4; end
            bif.out_ready = (stall == 0);
            bif.in_valid = (sent < 5);
            if (sent < 5) set_ops(md[sent], a[sent], b[sent], w[sent]);
            #1;
            if (hold_chk) begin
                nvec++; if (bif.out_valid !== 1'b1 || bif.output_1 !== h1 || bif.output_2 !== h2) begin nerr++; $display("FAIL bp_hold: got v=%b %0d,%0d expected v=1 %0d,%0d", bif.out_valid, bif.output_1, bif.output_2, h1, h2); end
            end
            exp_rdy = (inflight < 3) || bif.out_ready;
            nvec++; if (bif.in_ready !== exp_rdy) begin nerr++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, bif.in_ready, exp_rdy); end
            if (inflight == 3 && !bif.out_ready && bif.in_ready === 1'b0) full_seen = 1;
            if (bif.in_valid && bif.in_ready) begin
                exp_q.push_back(ref_bfly(md[sent], a[sent], b[sent], w[sent]));
                sent++; inflight++;
            end
            if (bif.out_valid && bif.out_ready) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++; $display("FAIL bp_spurious: got result %0d,%0d expected none", bif.output_1, bif.output_2);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.output_1, bif.output_2} !== e) begin nerr++; $display("FAIL bp_result%0d: got %0d,%0d expected %0d,%0d", got, bif.output_1, bif.output_2, e[2*W-1:W], e[W-1:0]); end
                end
                got++; inflight--;
            end
            hold_chk = bif.out_valid && !bif.out_ready;
            h1 = bif.output_1; h2 = bif.output_2;
            if (stall > 0) stall--;
            @(posedge clk); #1;
            cyc++;
        end
        nvec++; if (got != 5) begin nerr++; $display("FAIL bp_count: got %0d results expected 5", got); end
        nvec++; if (!full_seen) begin nerr++; $display("FAIL bp_full_stall: got full_seen %0d expected 1", full_seen); end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        bif.out_ready = 1'b1;
        bif.in_valid = 1'b1;
        set_ops(MODE_CT, rnd_op(), rnd_op(), rnd_op());
        @(posedge clk); #1;
        set_ops(MODE_GS, rnd_op(), rnd_op(), rnd_op());
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++; if (bif.out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_out_valid: got %b expected 0", bif.out_valid); end
        nvec++; if (bif.output_1 !== '0 || bif.output_2 !== '0) begin nerr++; $display("FAIL mid_rst_outputs: got %0d,%0d expected 0,0", bif.output_1, bif.output_2); end
        #1;
        nvec++; if (bif.in_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_in_ready: got %b expected 1", bif.in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            nvec++; if (bif.out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_stale: cycle %0d got out_valid %b expected 0", i, bif.out_valid); end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [2*W-1:0] e;
        logic [W-1:0]   h1, h2, a, b, w;
        logic           md;
        int sent, got, inflight, cyc;
        bit hold_chk, exp_rdy;
        exp_q.delete();
        sent = 0; got = 0; inflight = 0; cyc = 0; hold_chk = 0; h1 = '0; h2 = '0;
        md = 1'b0; a = '0; b = '0; w = '0;
        while ((sent < N || got < sent) && cyc < 60000) begin
            bif.in_valid = (sent < N) && ($urandom_range(0, 9) < 8);
            md = 1'($urandom_range(0, 1)); a = rnd_op(); b = rnd_op(); w = rnd_op();
            set_ops(md, a, b, w);
            bif.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (hold_chk) begin
                nvec++; if (bif.out_valid !== 1'b1 || bif.output_1 !== h1 || bif.output_2 !== h2) begin nerr++; $display("FAIL rnd_hold: cycle %0d got v=%b %0d,%0d expected v=1 %0d,%0d", cyc, bif.out_valid, bif.output_1, bif.output_2, h1, h2); end
            end
            exp_rdy = (inflight < 3) || bif.out_ready;
            nvec++; if (bif.in_ready !== exp_rdy) begin nerr++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", cyc, bif.in_ready, exp_rdy); end
            if (bif.in_valid && bif.in_ready) begin
                exp_q.push_back(ref_bfly(md, a, b, w));
                sent++; inflight++;
            end
            if (bif.out_valid && bif.out_ready) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++; $display("FAIL rnd_spurious: cycle %0d got %0d,%0d expected none", cyc, bif.output_1, bif.output_2);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.output_1, bif.output_2} !== e) begin nerr++; $display("FAIL rnd_result%0d: got %0d,%0d expected %0d,%0d", got, bif.output_1, bif.output_2, e[2*W-1:W], e[W-1:0]); end
                end
                got++; inflight--;
            end
            hold_chk = bif.out_valid && !bif.out_ready;
            h1 = bif.output_1; h2 = bif.output_2;
            @(posedge clk); #1;
            cyc++;
        end
        nvec++; if (got != N || sent != N) begin nerr++; $display("FAIL rnd_count: got %0d results from %0d sets expected %0d", got, sent, N); end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        set_ops(MODE_CT, '0, '0, '0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
